// File: rtl/shared_bus_driver_pkg.sv
// Shared definitions for the round-robin tri-state bus driver.
package shared_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_TURN  = 2'd2
  } state_e;

  localparam int unsigned CNT_W = 2;

  // Index width for a channel count; never below one bit.
  function automatic int unsigned owner_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shared_bus_driver_rr_pick.sv
// Combinational round-robin selector: first set mask bit at or above ptr, wrapping.
module rr_pick
  import shared_bus_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned IDX_W  = owner_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_mask,
  input  logic [IDX_W-1:0]  ptr,
  output logic [IDX_W-1:0]  winner_c,
  output logic              valid_c
);

  // Scan from the farthest offset down so the closest-to-ptr request wins last.
  always_comb begin
    int idx;
    winner_c = '0;
    valid_c  = 1'b0;
    idx      = 0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= int'(NUM_CH)) idx = idx - int'(NUM_CH);
      if (req_mask[IDX_W'(idx)]) begin
        winner_c = IDX_W'(idx);
        valid_c  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_bus_driver.sv
// Round-robin arbitrated driver for a shared tri-state bus with a
// configurable turnaround gap between owners.
module shared_bus_driver
  import shared_bus_pkg::*;
#(
  parameter  int unsigned WIDTH      = 32,
  parameter  int unsigned NUM_CH     = 4,
  parameter  int unsigned TURNAROUND = 1,
  localparam int unsigned OWNER_W    = owner_w(NUM_CH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    bus_en,
  input  logic [NUM_CH-1:0]       req,
  input  logic [NUM_CH*WIDTH-1:0] data_in,
  output logic [NUM_CH-1:0]       ack,
  output logic [WIDTH-1:0]        bus_out,
  output logic                    bus_oe,
  output logic [OWNER_W-1:0]      bus_owner,
  output logic                    busy
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [OWNER_W-1:0]   owner_q, owner_d;
  logic [OWNER_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 oe_q, oe_d;
  logic [NUM_CH-1:0]    ack_q, ack_d;
  logic                 busy_q, busy_d;

  logic [NUM_CH-1:0]    pick_mask_c;
  logic [OWNER_W-1:0]   win_c;
  logic                 win_vld_c;
  logic [WIDTH-1:0]     win_data_c;
  logic [OWNER_W-1:0]   win_next_c;
  logic                 grant_c;

  // The channel on the bus this cycle is excluded from a back-to-back grant.
  assign pick_mask_c = (state_q == ST_DRIVE) ? (req & ~ack_q) : req;

  rr_pick #(
    .NUM_CH (NUM_CH),
    .IDX_W  (OWNER_W)
  ) u_pick (
    .req_mask (pick_mask_c),
    .ptr      (ptr_q),
    .winner_c (win_c),
    .valid_c  (win_vld_c)
  );

  always_comb begin
    win_data_c = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (win_c == OWNER_W'(i)) win_data_c = data_in[i*WIDTH +: WIDTH];
    end
    win_next_c = (win_c == OWNER_W'(NUM_CH - 1)) ? '0 : OWNER_W'(win_c + 1'b1);
    grant_c    = bus_en && win_vld_c &&
                 ((state_q == ST_IDLE) || ((state_q == ST_DRIVE) && (TURNAROUND == 0)));
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_c) begin
          state_d = ST_DRIVE;
          data_d  = win_data_c;
          owner_d = win_c;
          ptr_d   = win_next_c;
        end
      end
      ST_DRIVE: begin
        if (TURNAROUND > 0) begin
          state_d = ST_TURN;
          cnt_d   = CNT_W'(TURNAROUND - 1);
        end else if (grant_c) begin
          state_d = ST_DRIVE;
          data_d  = win_data_c;
          owner_d = win_c;
          ptr_d   = win_next_c;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_TURN: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = CNT_W'(cnt_q - 1'b1);
      end
      default: state_d = ST_IDLE;
    endcase
    oe_d   = (state_d == ST_DRIVE);
    ack_d  = oe_d ? (NUM_CH'(1) << owner_d) : '0;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      oe_q    <= 1'b0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      oe_q    <= oe_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign bus_out   = oe_q ? data_q : {WIDTH{1'bz}};
  assign bus_oe    = oe_q;
  assign ack       = ack_q;
  assign bus_owner = owner_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_shared_bus_driver.sv
// Scoreboard bench for shared_bus_driver: three configurations
// (4ch/turn1, 4ch/turn0, 3ch/turn2) checked against hand-timed expected drives.
module tb_shared_bus_driver;

  typedef struct {
    int          cyc;
    int          ch;
    logic [31:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b1;
  int           cyc = 0;
  logic         mon_en = 1'b0;

  logic [3:0]   req0 = '0, req1 = '0;
  logic [2:0]   req2 = '0;
  logic [127:0] din0, din1;
  logic [95:0]  din2;
  logic [3:0]   ack0, ack1;
  logic [2:0]   ack2;
  wire  [31:0]  bus0, bus1, bus2;
  logic         oe0, oe1, oe2;
  logic [1:0]   own0, own1, own2;
  logic         busy0, busy1, busy2;

  exp_t q0[$], q1[$], q2[$];
  int   n_pass = 0, n_tot = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shared_bus_driver #(.WIDTH(32), .NUM_CH(4), .TURNAROUND(1)) u_dut0 (
    .clock(clk), .reset(rst), .bus_en(en), .req(req0), .data_in(din0),
    .ack(ack0), .bus_out(bus0), .bus_oe(oe0), .bus_owner(own0), .busy(busy0));

  shared_bus_driver #(.WIDTH(32), .NUM_CH(4), .TURNAROUND(0)) u_dut1 (
    .clock(clk), .reset(rst), .bus_en(en), .req(req1), .data_in(din1),
    .ack(ack1), .bus_out(bus1), .bus_oe(oe1), .bus_owner(own1), .busy(busy1));

  shared_bus_driver #(.WIDTH(32), .NUM_CH(3), .TURNAROUND(2)) u_dut2 (
    .clock(clk), .reset(rst), .bus_en(en), .req(req2), .data_in(din2),
    .ack(ack2), .bus_out(bus2), .bus_oe(oe2), .bus_owner(own2), .busy(busy2));

  task automatic check(input string nm, input longint got, input longint exp);
    n_tot++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
  endtask

  // Advance n cycles; each requester drops req the cycle after its ack.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      logic [3:0] a0, a1;
      logic [2:0] a2;
      a0 = ack0; a1 = ack1; a2 = ack2;
      @(posedge clk); #1;
      req0 = req0 & ~a0;
      req1 = req1 & ~a1;
      req2 = req2 & ~a2;
    end
  endtask

  task automatic expect_drive(input int dut, input int dcyc, input int ch, input logic [31:0] d);
    exp_t e;
    e.cyc = cyc + dcyc; e.ch = ch; e.data = d;
    case (dut)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic reset_all();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic mon(input int dut, input logic oe, input logic [3:0] ack,
                     input logic [31:0] bus, input logic [1:0] own);
    exp_t e;
    int   sz;
    case (dut)
      0: sz = q0.size();
      1: sz = q1.size();
      default: sz = q2.size();
    endcase
    if (!oe) begin
      check($sformatf("d%0d_idle_ack", dut), longint'(ack), 0);
    end else if (sz == 0) begin
      check($sformatf("d%0d_unexpected_drive_ch", dut), longint'(own), -1);
    end else begin
      case (dut)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      check($sformatf("d%0d_drive_cycle", dut), longint'(cyc), longint'(e.cyc));
      check($sformatf("d%0d_ack", dut), longint'(ack), longint'(1) << e.ch);
      check($sformatf("d%0d_bus_data", dut), longint'(bus), longint'(e.data));
      check($sformatf("d%0d_owner", dut), longint'(own), longint'(e.ch));
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, oe0, ack0, bus0, own0);
      mon(1, oe1, ack1, bus1, own1);
      mon(2, oe2, {1'b0, ack2}, bus2, own2);
    end
  end

  initial begin
    din0 = {32'hC000_0003, 32'hDEAD_BEEF, 32'hC000_0001, 32'hC000_0000};
    din1 = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    din2 = {32'hBBBB_0002, 32'hBBBB_0001, 32'hBBBB_0000};

    step(2);
    check("rst_oe",    longint'(oe0),   0);
    check("rst_ack",   longint'(ack0),  0);
    check("rst_busy",  longint'(busy0), 0);
    check("rst_owner", longint'(own0),  0);
    check("rst_busy_d2", longint'(busy2), 0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Single request, one drive cycle then released
    req0 = 4'b0100;
    expect_drive(0, 1, 2, 32'hDEAD_BEEF);
    step(4);

    // All four requesting: rotating order, three cycles apart
    reset_all();
    req0 = 4'b1111;
    expect_drive(0, 1,  0, 32'hC000_0000);
    expect_drive(0, 4,  1, 32'hC000_0001);
    expect_drive(0, 7,  2, 32'hDEAD_BEEF);
    expect_drive(0, 10, 3, 32'hC000_0003);
    step(13);

    // bus_en low blocks the grant; raising it grants the next cycle
    reset_all();
    en   = 1'b0;
    req0 = 4'b0001;
    step(5);
    en = 1'b1;
    expect_drive(0, 1, 0, 32'hC000_0000);
    step(4);

    // Reset during a drive cycle, pending ch3 granted right after release
    reset_all();
    req0 = 4'b0010;
    expect_drive(0, 1, 1, 32'hC000_0001);
    step(1);
    rst  = 1'b1;
    req0 = 4'b1000;
    step(1);
    check("midrst_oe",    longint'(oe0),   0);
    check("midrst_ack",   longint'(ack0),  0);
    check("midrst_busy",  longint'(busy0), 0);
    check("midrst_owner", longint'(own0),  0);
    rst = 1'b0;
    expect_drive(0, 1, 3, 32'hC000_0003);
    step(4);

    // Zero turnaround: back-to-back drives
    reset_all();
    req1 = 4'b0011;
    expect_drive(1, 1, 0, 32'h1111_1111);
    expect_drive(1, 2, 1, 32'h2222_2222);
    step(4);
    reset_all();
    req1 = 4'b1111;
    expect_drive(1, 1, 0, 32'h1111_1111);
    expect_drive(1, 2, 1, 32'h2222_2222);
    expect_drive(1, 3, 2, 32'h3333_3333);
    expect_drive(1, 4, 3, 32'h4444_4444);
    step(7);

    // Three channels, turnaround 2: pointer wraps 2 -> 0
    reset_all();
    req2 = 3'b100;
    expect_drive(2, 1, 2, 32'hBBBB_0002);
    step(2);
    req2 = 3'b101;
    expect_drive(2, 3, 0, 32'hBBBB_0000);
    expect_drive(2, 7, 2, 32'hBBBB_0002);
    step(10);

    check("q0_left", longint'(q0.size()), 0);
    check("q1_left", longint'(q1.size()), 0);
    check("q2_left", longint'(q2.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
